// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory target for the MEM stage. Accepts one load/store request at a
// time, waits a fixed LATENCY cycles, performs the access against a word-wide
// RAM using little-endian byte lanes, and holds the response until the
// initiator takes it. Loads are shifted down to bit 0 and sign- or
// zero-extended. A misaligned access or a reserved size writes nothing and
// returns resp_err=1 with resp_rdata=0.
//
// Parameters:
//   ADDR_WIDTH  log2 of the RAM word count. The word index is
//               req_addr[ADDR_WIDTH+1:2]; higher address bits alias.
//   LATENCY     cycles from request acceptance to resp_valid (1..15).
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   req_valid   request present                  (in)
//   req_ready   request can be accepted          (out, high only when idle)
//   req_write   1 = store, 0 = load              (in)
//   req_addr    byte address                     (in, 32)
//   req_wdata   store data, low bits used        (in, 32)
//   req_size    00 byte, 01 half, 10 word        (in, 2; 11 is an error)
//   req_signed  load extension: 1 sign, 0 zero   (in)
//   resp_valid  response available              (out)
//   resp_ready  initiator takes the response     (in)
//   resp_rdata  extended load data, 0 otherwise  (out, 32)
//   resp_err    misaligned or reserved size      (out)
//
// Build option:
//   DMEM_STATS_EN  adds saturating 16-bit counters stat_loads, stat_stores,
//                  stat_errs and stat_busy as outputs.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs,
  output logic [15:0] stat_busy
`endif
);

  localparam int unsigned Words = 2 ** ADDR_WIDTH;
  localparam int unsigned AW    = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  state_e       r_state;
  logic [3:0]   r_cnt;
  logic         r_write;
  logic [AW-1:0] r_addr;
  logic [31:0]  r_wdata;
  logic [1:0]   r_size;
  logic         r_signed;
  logic         r_resp_valid;
  logic [31:0]  r_resp_rdata;
  logic         r_resp_err;

  logic [31:0]  r_mem [Words];

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_err;
  logic                  w_access;
  logic                  w_we;
  logic [31:0]           w_rword;
  logic [31:0]           w_shift_b;
  logic [31:0]           w_shift_h;
  logic [31:0]           w_load;
  logic [3:0]            w_be;
  logic [31:0]           w_lane;

  // Address bits above the RAM span are deliberately ignored (aliasing).
  logic w_unused_addr;
  assign w_unused_addr = ^req_addr[31:AW];

  assign w_idx   = r_addr[AW-1:2];
  assign w_rword = r_mem[w_idx];

  // The access happens on the last BUSY cycle.
  assign w_access = (r_state == StBusy) && (r_cnt == 4'd0);
  assign w_we     = w_access && r_write && !w_err;

  // Alignment / reserved-size check.
  always_comb begin
    w_err = 1'b0;
    case (r_size)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = r_addr[0];
      2'b10:   w_err = |r_addr[1:0];
      default: w_err = 1'b1;
    endcase
  end

  // Load path: move the selected lane down to bit 0, then extend.
  assign w_shift_b = w_rword >> {r_addr[1:0], 3'b000};
  assign w_shift_h = w_rword >> {r_addr[1], 4'b0000};

  always_comb begin
    w_load = '0;
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_shift_b[7]}}, w_shift_b[7:0]};
      2'b01:   w_load = {{16{r_signed & w_shift_h[15]}}, w_shift_h[15:0]};
      2'b10:   w_load = w_rword;
      default: w_load = '0;
    endcase
  end

  // Store path: replicate the low data across lanes and let the byte enables
  // pick which lanes are written.
  always_comb begin
    w_be   = 4'b0000;
    w_lane = '0;
    case (r_size)
      2'b00: begin
        w_be   = 4'b0001 << r_addr[1:0];
        w_lane = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_lane = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_be   = 4'b1111;
        w_lane = r_wdata;
      end
      default: begin
        w_be   = 4'b0000;
        w_lane = '0;
      end
    endcase
  end

  // RAM contents survive reset; writes only ever commit on the BUSY->RESP edge,
  // and an asynchronous reset forces IDLE first so a dropped request never
  // reaches the array.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_lane[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_addr   <= req_addr[AW-1:0];
            r_wdata  <= req_wdata;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_cnt    <= 4'(LATENCY - 1);
            r_state  <= StBusy;
          end
        end
        StBusy: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= (r_write || w_err) ? 32'd0 : w_load;
            r_resp_err   <= w_err;
            r_state      <= StResp;
          end
        end
        StResp: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Ready is gated by rst so it is low for the whole time reset is held.
  assign req_ready  = (r_state == StIdle) && rst;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

`ifdef DMEM_STATS_EN
  logic [15:0] r_stat_loads;
  logic [15:0] r_stat_stores;
  logic [15:0] r_stat_errs;
  logic [15:0] r_stat_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_loads  <= '0;
      r_stat_stores <= '0;
      r_stat_errs   <= '0;
      r_stat_busy   <= '0;
    end else begin
      if (w_access && !w_err && !r_write && (r_stat_loads != 16'hFFFF)) begin
        r_stat_loads <= r_stat_loads + 16'd1;
      end
      if (w_access && !w_err && r_write && (r_stat_stores != 16'hFFFF)) begin
        r_stat_stores <= r_stat_stores + 16'd1;
      end
      if (w_access && w_err && (r_stat_errs != 16'hFFFF)) begin
        r_stat_errs <= r_stat_errs + 16'd1;
      end
      if ((r_state != StIdle) && (r_stat_busy != 16'hFFFF)) begin
        r_stat_busy <= r_stat_busy + 16'd1;
      end
    end
  end

  assign stat_loads  = r_stat_loads;
  assign stat_stores = r_stat_stores;
  assign stat_errs   = r_stat_errs;
  assign stat_busy   = r_stat_busy;
`endif

endmodule
